// File: rtl/seq_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seq_scan_ctrl
//
// Word-to-bit sequencing controller wrapped around an overlapping "1001"
// detector. A parallel word is accepted over a valid/ready handshake, shifted
// MSB-first into the detector one bit per clock, and the number of matches
// completed inside that word is then offered on a result handshake. A 16-bit
// saturating total of all matches since reset/clear is kept alongside.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds in_valid/in_data stable until it sees in_ready;
// the controller holds out_valid/out_count/total_count stable until it sees
// out_ready. in_ready is a combinational decode; every other output is a flop.
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   in_valid     producer offers in_data
//   in_ready     word accepted this cycle (IDLE and no clear)
//   in_data      word to scan, bit WIDTH-1 shifted first
//   clear        restart detector history and total_count (IDLE only)
//   out_valid    per-word result available
//   out_ready    consumer takes the result
//   out_count    matches completed within the reported word
//   total_count  saturating match total since reset/clear
//   busy         high in SHIFT or REPORT
//   det_state    detector state code (D0..D4)
//   ctrl_state   control FSM state code (IDLE=0, SHIFT=1, REPORT=2)
// -----------------------------------------------------------------------------
module seq_scan_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] out_count,
   output logic [15:0]      total_count,
   output logic             busy,
   output logic [2:0]       det_state,
   output logic [1:0]       ctrl_state
);

   localparam int BCW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_REPORT = 2'd2
   } ctrl_e;

   // Detector codes are kept as a plain 3-bit vector so that the unused
   // codes 101..111 are representable and recover to D0.
   localparam logic [2:0] D0 = 3'b000;
   localparam logic [2:0] D1 = 3'b001;
   localparam logic [2:0] D2 = 3'b010;
   localparam logic [2:0] D3 = 3'b011;
   localparam logic [2:0] D4 = 3'b100;

   ctrl_e            state_q, state_d;
   logic [2:0]       det_q, det_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [BCW-1:0]   cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic [CNT_W-1:0] out_count_q, out_count_d;
   logic [15:0]      total_q, total_d;
   logic             busy_q, busy_d;
   logic [2:0]       det_nxt;

   // Overlapping 1001 transition function. After a match (D4) the trailing
   // '1' is reused as the start of the next pattern.
   function automatic logic [2:0] det_next(input logic [2:0] cur, input logic b);
      logic [2:0] nxt;
      case (cur)
         D0:      nxt = b ? D1 : D0;
         D1:      nxt = b ? D1 : D2;
         D2:      nxt = b ? D1 : D3;
         D3:      nxt = b ? D4 : D0;
         D4:      nxt = b ? D1 : D2;
         default: nxt = D0;
      endcase
      return nxt;
   endfunction

   // Accept only when idle; clear wins over a pending word.
   assign in_ready = (state_q == ST_IDLE) && !clear;

   always_comb begin
      state_d     = state_q;
      det_d       = det_q;
      shreg_d     = shreg_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_count_d = out_count_q;
      total_d     = total_q;
      busy_d      = busy_q;
      det_nxt     = det_next(det_q, shreg_q[WIDTH-1]);

      case (state_q)
         ST_IDLE: begin
            if (clear) begin
               det_d   = D0;
               total_d = 16'd0;
            end else if (in_valid) begin
               shreg_d     = in_data;
               cnt_d       = BCW'(WIDTH);
               out_count_d = '0;
               state_d     = ST_SHIFT;
               busy_d      = 1'b1;
            end
         end

         ST_SHIFT: begin
            det_d   = det_nxt;
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q - BCW'(1);
            if (det_nxt == D4) begin
               out_count_d = out_count_q + CNT_W'(1);
               if (total_q != 16'hFFFF) begin
                  total_d = total_q + 16'd1;
               end
            end
            // Last bit of the word is being shifted on this edge.
            if (cnt_q == BCW'(1)) begin
               state_d     = ST_REPORT;
               out_valid_d = 1'b1;
            end
         end

         ST_REPORT: begin
            if (out_ready) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
               busy_d      = 1'b0;
            end
         end

         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         det_q       <= D0;
         shreg_q     <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_count_q <= '0;
         total_q     <= 16'd0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         det_q       <= det_d;
         shreg_q     <= shreg_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_count_q <= out_count_d;
         total_q     <= total_d;
         busy_q      <= busy_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_count   = out_count_q;
   assign total_count = total_q;
   assign busy        = busy_q;
   assign det_state   = det_q;
   assign ctrl_state  = state_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_scan_ctrl
//
// Directed and randomized words for seq_scan_ctrl. The reference model keeps
// the last few bits fed to the detector and recognises a match as "the last
// four bits are 1,0,0,1"; the detector state is the longest suffix of that
// history that is a prefix of 1001.
// -----------------------------------------------------------------------------
module tb_seq_scan_ctrl;
   localparam int WIDTH = 8;
   localparam int CNT_W = 4;

   // ---------------- clock / reset ----------------
   logic             clock = 1'b0;
   logic             reset;
   logic             in_valid, in_ready, clear, out_valid, out_ready, busy;
   logic [WIDTH-1:0] in_data;
   logic [CNT_W-1:0] out_count;
   logic [15:0]      total_count;
   logic [2:0]       det_state;
   logic [1:0]       ctrl_state;

   always #5 clock = ~clock;

   seq_scan_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clock       (clock),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .clear       (clear),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_count   (out_count),
      .total_count (total_count),
      .busy        (busy),
      .det_state   (det_state),
      .ctrl_state  (ctrl_state)
   );

   // ---------------- scoreboard state ----------------
   int               checks   = 0;
   int               failures = 0;
   logic [CNT_W-1:0] exp_q[$];
   bit               hist[$];
   int               model_total;
   logic [CNT_W-1:0] last_count;
   logic [15:0]      last_total;
   logic [2:0]       last_det;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int model_det();
      int n;
      n = hist.size();
      if (n >= 4 && hist[n-4] && !hist[n-3] && !hist[n-2] && hist[n-1]) return 4;
      if (n >= 3 && hist[n-3] && !hist[n-2] && !hist[n-1]) return 3;
      if (n >= 2 && hist[n-2] && !hist[n-1]) return 2;
      if (n >= 1 && hist[n-1]) return 1;
      return 0;
   endfunction

   task automatic model_word(input logic [WIDTH-1:0] w, output int hits);
      hits = 0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         hist.push_back(w[i]);
         if (hist.size() > 4) void'(hist.pop_front());
         if (model_det() == 4) begin
            hits++;
            if (model_total < 65535) model_total++;
         end
      end
   endtask

   task automatic model_clear();
      hist.delete();
      model_total = 0;
   endtask

   // ---------------- driver tasks (called at a negedge) ----------------
   task automatic send_word(input logic [WIDTH-1:0] w, input int hold);
      int hits;
      int budget;
      logic [CNT_W-1:0] exp_cnt;
      budget = 0;
      while (!in_ready && budget < 20) begin
         @(negedge clock);
         budget++;
      end
      #1;
      check_eq("in_ready_idle", in_ready, 1);
      in_valid = 1'b1;
      in_data  = w;
      model_word(w, hits);
      exp_q.push_back(CNT_W'(hits));
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      in_data  = WIDTH'($urandom);
      #1;
      check_eq("busy_shift", busy, 1);
      check_eq("in_ready_shift", in_ready, 0);
      repeat (WIDTH - 1) @(negedge clock);
      check_eq("out_valid_early", out_valid, 0);
      @(negedge clock);
      check_eq("out_valid", out_valid, 1);
      exp_cnt = exp_q.pop_front();
      check_eq("out_count", out_count, exp_cnt);
      check_eq("total_count", total_count, model_total);
      check_eq("det_state", det_state, model_det());
      last_count = out_count;
      last_total = total_count;
      last_det   = det_state;
      for (int h = 0; h < hold; h++) begin
         @(negedge clock);
         check_eq("hold_out_valid", out_valid, 1);
         check_eq("hold_out_count", out_count, exp_cnt);
         check_eq("hold_total", total_count, model_total);
         check_eq("hold_in_ready", in_ready, 0);
         check_eq("hold_busy", busy, 1);
      end
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
      check_eq("idle_out_valid", out_valid, 0);
      check_eq("idle_busy", busy, 0);
      check_eq("idle_in_ready", in_ready, 1);
   endtask

   task automatic do_clear();
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h20;
      #1;
      check_eq("in_ready_clear", in_ready, 0);
      @(negedge clock);
      clear    = 1'b0;
      in_valid = 1'b0;
      model_clear();
      check_eq("clear_busy", busy, 0);
      check_eq("clear_total", total_count, 0);
      check_eq("clear_det", det_state, 0);
      check_eq("clear_ctrl", ctrl_state, 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      in_valid  = 1'b0;
      in_data   = '0;
      clear     = 1'b0;
      out_ready = 1'b0;
      reset     = 1'b1;
      model_clear();
      #1 reset = 1'b0;
      repeat (2) @(negedge clock);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_out_count", out_count, 0);
      check_eq("rst_total", total_count, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_det", det_state, 0);
      check_eq("rst_in_ready", in_ready, 1);
      reset = 1'b1;
      @(negedge clock);

      send_word(8'h99, 0);
      check_eq("w99_count", last_count, 2);
      check_eq("w99_total", last_total, 2);
      check_eq("w99_det", last_det, 3'b100);

      send_word(8'h92, 1);
      check_eq("w92_count", last_count, 2);
      check_eq("w92_det", last_det, 3'b010);

      do_clear();
      send_word(8'h01, 0);
      check_eq("x01_count", last_count, 0);
      check_eq("x01_det", last_det, 3'b001);
      send_word(8'h20, 0);
      check_eq("x20_count", last_count, 1);
      check_eq("x20_total", last_total, 1);

      do_clear();
      send_word(8'h01, 0);
      do_clear();
      send_word(8'h20, 0);
      check_eq("clr20_count", last_count, 0);
      check_eq("clr20_total", last_total, 0);

      send_word(8'h99, 5);

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 7) == 0) do_clear();
         send_word(WIDTH'($urandom_range(0, 255)), $urandom_range(0, 3));
      end

      // Make sure the total is non-zero before the mid-word reset.
      send_word(8'h99, 0);
      in_valid = 1'b1;
      in_data  = 8'hFF;
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      repeat (2) @(negedge clock);
      check_eq("mid_busy_before", busy, 1);
      reset = 1'b0;
      #1;
      model_clear();
      check_eq("mid_out_valid", out_valid, 0);
      check_eq("mid_out_count", out_count, 0);
      check_eq("mid_total", total_count, 0);
      check_eq("mid_busy", busy, 0);
      check_eq("mid_det", det_state, 0);
      check_eq("mid_ctrl", ctrl_state, 0);
      check_eq("mid_in_ready", in_ready, 1);
      @(negedge clock);
      reset = 1'b1;
      repeat (WIDTH + 2) @(negedge clock);
      check_eq("post_rst_out_valid", out_valid, 0);
      send_word(8'h09, 0);
      check_eq("w09_count", last_count, 1);
      check_eq("w09_total", last_total, 1);

      check_eq("exp_q_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Sequencing controller for the serial "1001" pattern detector. It accepts parallel words over a valid/ready handshake and shifts them MSB-first, one bit per clock, through an integrated overlapping 1001 detector. After each word it reports the per-word match count, and it keeps a running saturating total. It sits between a word-oriented producer and the bit-serial detection datapath, so upstream logic never drives the detector bit by bit.

## Interface
- WIDTH, 8: data word width in bits (≥4)
- CNT_W, 4: per-word match count width; must hold WIDTH/3+1
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- in_valid  in  1  producer has a word on in_data
- in_ready  out  1  controller accepts a word this cycle
- in_data  in  WIDTH  word to scan; bit WIDTH-1 is shifted first
- clear  in  1  synchronous restart of detector history and total_count
- out_valid  out  1  per-word result available
- out_ready  in  1  consumer takes the result
- out_count  out  CNT_W  matches completed within the reported word
- total_count  out  16  saturating count of all matches since reset/clear
- busy  out  1  high in SHIFT or REPORT
- det_state  out  3  current detector state code

## Operation
- Control FSM has three states: IDLE, SHIFT, REPORT.
  - IDLE → SHIFT on in_valid && in_ready. The word is loaded into the shift register, bit counter = WIDTH, and out_count is zeroed.
  - SHIFT: each cycle the shift-register MSB is fed to the detector, the register shifts left and the counter decrements. When the counter reaches 0 the FSM goes to REPORT.
  - REPORT → IDLE on out_ready. out_valid is held until then.
- Detector states and codes: D0=000 (no prefix), D1=001 ("1"), D2=010 ("10"), D3=011 ("100"), D4=100 (match).
  - D0: 1→D1, 0→D0
  - D1: 1→D1, 0→D2
  - D2: 1→D1, 0→D3
  - D3: 1→D4, 0→D0
  - D4: 1→D1, 0→D2
  - Illegal codes → D0.
- Detector history persists across words. A match whose final bit lands in word N counts in word N, even if its first bits were in word N-1.
- A hit is a SHIFT cycle whose detector next-state is D4. On each hit, out_count increments and total_count increments, saturating at 0xFFFF.
- The detector advances only in SHIFT cycles and holds state in IDLE and REPORT.
- clear acts only in IDLE. It sets the detector to D0 and total_count to 0, and takes priority over accepting a word. clear is ignored in SHIFT and REPORT.
- Reset values: FSM IDLE, detector D0, in_ready=1 (when clear=0), out_valid=0, out_count=0, total_count=0, busy=0, det_state=000, shift register 0.

## Timing
- in_ready = (FSM==IDLE) && !clear, combinational. All other outputs are registered.
- Latency: a word accepted at edge T is shifted on edges T+1..T+WIDTH. out_valid is high from just after edge T+WIDTH until the edge where out_ready=1.
- Minimum word period is WIDTH+2 cycles: accept, WIDTH shifts, one REPORT cycle with out_ready=1, back to IDLE. A new word can be accepted on the first IDLE cycle after that.
- out_count and total_count are stable while out_valid=1.
- Asserting reset mid-SHIFT or mid-REPORT immediately forces all reset values. The partial word is discarded and no out_valid is produced for it.
- in_valid while busy is ignored. The producer must hold the word until in_ready.

## Test plan
- Reset, then word 0x99 (1001_1001) → out_valid after 8 shift cycles, out_count=2, total_count=2, det_state=100.
- Word 0x92 (1001_0010), overlap case → out_count=2, final det_state=010.
- Cross-boundary: 0x01 then 0x20 with no clear → first out_count=0 (ends D1), second out_count=1, total_count=1.
- Same 0x01 / 0x20 pair with clear pulsed in IDLE between the words → second out_count=0, total_count=0, and in_ready=0 during the clear cycle.
- Backpressure: hold out_ready=0 for 5 cycles in REPORT → out_valid, out_count and total_count stable, in_ready=0, busy=1; then out_ready=1 → IDLE next cycle.
- Drive reset low in the 3rd SHIFT cycle of 0xFF → all outputs at reset values asynchronously. After release, 0x09 (0000_1001) gives out_count=1.
